// File: rtl/rename_regfile_pkg.sv
// Shared widths, bus types and constants for the rename/architectural register file.
package rename_regfile_pkg;
  localparam int REG_NUM = 32;
  localparam int REG_W   = 5;
  localparam int TAG_W   = 4;
  localparam int DATA_W  = 32;

  typedef logic [REG_W-1:0]  RegBus;
  typedef logic [TAG_W-1:0]  TagBus;
  typedef logic [DATA_W-1:0] DataBus;

  localparam logic   Valid   = 1'b1;
  localparam logic   Invalid = 1'b0;
  localparam logic   Ready   = 1'b1;
  localparam logic   Unready = 1'b0;
  localparam DataBus Null    = '0;
endpackage

// File: rtl/rename_regfile_read_port.sv
// One dispatch read port: x0 forcing, commit-stream bypass, busy/tag or committed-data select.
module rename_regfile_read_port
  import rename_regfile_pkg::*;
(
  input  RegBus  addr,
  input  logic   busy,
  input  TagBus  tag,
  input  DataBus data,
  input  logic   cdb_valid,
  input  RegBus  cdb_reg_dest,
  input  TagBus  cdb_tag,
  input  DataBus cdb_data,
  output logic   reg_valid,
  output TagBus  reg_tag,
  output DataBus reg_data
);

  always_comb begin
    reg_valid = Invalid;
    reg_tag   = '0;
    reg_data  = Null;
    if (addr != '0) begin
      reg_tag = tag;
      // A commit of the exact producer this cycle resolves the dependency early.
      if (busy && cdb_valid && (cdb_reg_dest == addr) && (cdb_tag == tag)) begin
        reg_data = cdb_data;
      end else if (busy) begin
        reg_valid = Valid;
      end else begin
        reg_data = data;
      end
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file plus rename tag table fed by the ROB commit stream.
// Optional REGFILE_COMMIT_TRACE_EN adds a commit counter port and a simulation commit trace.
module rename_regfile
  import rename_regfile_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   rdy,
  input  logic   clear,
  input  logic   ID_valid,
  input  RegBus  ID_dest_reg,
  input  TagBus  ID_tag,
  input  RegBus  ID_reg1_addr,
  input  RegBus  ID_reg2_addr,
  output logic   dispatch_reg1_valid,
  output TagBus  dispatch_reg1_tag,
  output DataBus dispatch_reg1_data,
  output logic   dispatch_reg2_valid,
  output TagBus  dispatch_reg2_tag,
  output DataBus dispatch_reg2_data,
`ifdef REGFILE_COMMIT_TRACE_EN
  output logic [31:0] debug_commit_cnt,
`endif
  input  logic   CDB_valid,
  input  RegBus  CDB_reg_dest,
  input  TagBus  CDB_tag,
  input  DataBus CDB_data
);

  DataBus data_q [REG_NUM];
  TagBus  tag_q  [REG_NUM];
  logic   busy_q [REG_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        data_q[i] <= Null;
        tag_q[i]  <= '0;
        busy_q[i] <= 1'b0;
      end
    end else if (rdy != Unready) begin
      if (CDB_valid && (CDB_reg_dest != '0)) begin
        data_q[CDB_reg_dest] <= CDB_data;
        // Only the newest producer may release the register.
        if (busy_q[CDB_reg_dest] && (tag_q[CDB_reg_dest] == CDB_tag))
          busy_q[CDB_reg_dest] <= 1'b0;
      end
      // Later assignments win: flush beats rename, rename beats commit release.
      if (clear) begin
        for (int i = 0; i < REG_NUM; i++)
          busy_q[i] <= 1'b0;
      end else if (ID_valid && (ID_dest_reg != '0)) begin
        busy_q[ID_dest_reg] <= 1'b1;
        tag_q[ID_dest_reg]  <= ID_tag;
      end
    end
  end

  rename_regfile_read_port u_port1 (
    .addr         (ID_reg1_addr),
    .busy         (busy_q[ID_reg1_addr]),
    .tag          (tag_q[ID_reg1_addr]),
    .data         (data_q[ID_reg1_addr]),
    .cdb_valid    (CDB_valid),
    .cdb_reg_dest (CDB_reg_dest),
    .cdb_tag      (CDB_tag),
    .cdb_data     (CDB_data),
    .reg_valid    (dispatch_reg1_valid),
    .reg_tag      (dispatch_reg1_tag),
    .reg_data     (dispatch_reg1_data)
  );

  rename_regfile_read_port u_port2 (
    .addr         (ID_reg2_addr),
    .busy         (busy_q[ID_reg2_addr]),
    .tag          (tag_q[ID_reg2_addr]),
    .data         (data_q[ID_reg2_addr]),
    .cdb_valid    (CDB_valid),
    .cdb_reg_dest (CDB_reg_dest),
    .cdb_tag      (CDB_tag),
    .cdb_data     (CDB_data),
    .reg_valid    (dispatch_reg2_valid),
    .reg_tag      (dispatch_reg2_tag),
    .reg_data     (dispatch_reg2_data)
  );

`ifdef REGFILE_COMMIT_TRACE_EN
  // Counts every accepted commit, x0 included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      debug_commit_cnt <= '0;
    else if ((rdy == Ready) && CDB_valid)
      debug_commit_cnt <= debug_commit_cnt + 32'd1;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && (rdy == Ready) && CDB_valid && (CDB_reg_dest != '0))
      $display("reg %0d %h", CDB_reg_dest, CDB_data);
  end
`endif
`endif

endmodule
